ball_ctrl: RTL and testbench
============================

Name: ball_ctrl

Overview:
- Ball motion engine for the Pong core.
- Holds ball position, direction and speed.
- Advances the ball once per video frame on a frame tick.
- Handles wall bounces, paddle deflection and misses.
- Publishes the ball as a sprite_t to the pixel renderer, and one-cycle score pulses to the score/LED logic.
- Sits between the paddle controllers (which supply player/enemy sprites) and the draw/compositor stage.

Parameters:
- SERVE_FRAMES, 60, frames waited in SERVE before launch.
- BASE_SPEED_X, 2, horizontal px/frame at each serve.
- MAX_SPEED_X, 7, horizontal speed saturation (fits SPEED_W-2 bits).
- EDGE_ZONE, 10, px band at each end of a paddle treated as an edge hit.

Ports:
- clk_i  in  1  pixel-domain clock
- rst_n_i  in  1  asynchronous active-low reset
- frame_tick_i  in  1  one-cycle pulse per frame, start of vertical blank
- start_i  in  1  level; leaves IDLE
- rnd_i  in  RND_NUM_W  LFSR value, sampled at launch
- player_i  in  sprite_t  left paddle
- enemy_i  in  sprite_t  right paddle
- ball_o  out  sprite_t  ball bounding box (right = x+BALL_SIDE-1, bottom = y+BALL_SIDE-1)
- player_scored_o  out  1  one-cycle pulse, ball exited right edge
- enemy_scored_o  out  1  one-cycle pulse, ball exited left edge
- ball_active_o  out  1  high in MOVE

Behaviour:
- Reset (async, rst_n_i low):
  - state = IDLE; ball x=315, y=235 (centre minus BALL_SIDE/2).
  - speed_x=BASE_SPEED_X, speed_y=0, dx=left, dy=down, serve counter 0.
  - All pulse outputs 0; ball_active_o 0.
- Reset mid-operation returns immediately to these values. No partial update survives.
- FSM:
  - IDLE: start_i=1 -> SERVE.
  - SERVE: counter increments on each frame_tick_i. On the tick where counter reaches SERVE_FRAMES-1 -> MOVE.
    - At launch, load speed_x=BASE_SPEED_X, dy=rnd_i[0] (1=down), speed_y=rnd_i[2:1].
    - dx is unchanged: left after reset, otherwise toward the side that lost the last point.
  - MOVE: position updates on each frame_tick_i; a miss -> SCORE.
  - SCORE: lasts exactly one clock. Assert the matching score pulse, recentre the ball, clear counter -> SERVE.
- start_i is ignored outside IDLE. frame_tick_i is ignored in IDLE and SCORE.
- Update latency: new ball_o is registered and visible the cycle after frame_tick_i. Only MOVE updates, so ball_o changes at most once per frame.
- Arithmetic:
  - Next x/y computed signed, X_POS_W+1 / Y_POS_W+1 bits, so underflow is detectable.
  - speed_x is SPEED_W-2 bits; speed_y is SPEED_W-1 bits.
- Vertical walls:
  - next y < SCREEN_BORDER -> y=SCREEN_BORDER, dy=down.
  - next bottom > SCREEN_V_RES-1-SCREEN_BORDER -> y clamped so bottom equals that limit, dy=up.
- Paddle hit, player side (dx=left):
  - Condition: current x > player.right, next x <= player.right, and vertical overlap (ball bottom >= player.y_pos and ball y <= player.bottom).
  - Response: x=player.right+1, dx=right.
- Paddle hit, enemy side: mirrored; x=enemy.x_pos-BALL_SIDE, dx=left.
- Paddle hit effects (both sides):
  - speed_x += 1, saturating at MAX_SPEED_X.
  - Ball centre y (y+BALL_SIDE/2) within EDGE_ZONE of the paddle top -> speed_y=5, dy=up.
  - Within EDGE_ZONE of the paddle bottom -> speed_y=5, dy=down.
  - Otherwise speed_y=1, dy unchanged.
- Miss:
  - next x < 0 -> enemy_scored_o.
  - next right > SCREEN_H_RES-1 -> player_scored_o.
  - Either miss is taken only if no paddle hit fired that frame. Paddle hit has priority.
- Simultaneous wall and paddle hit in one frame: both corrections applied independently (x/dx from paddle, y/dy from wall; the edge-zone dy is overridden by the wall flip).
- Score pulses are mutually exclusive and never overlap ball_active_o.

Decomposition:
- Shared package: add ball_state_t enum (IDLE, SERVE, MOVE, SCORE), BALL_CENTER_X/BALL_CENTER_Y constants, BASE_SPEED_X, MAX_SPEED_X, EDGE_ZONE.
- Reuse the existing sprite_t, BALL_SIDE, SCREEN_BORDER, SPEED_W.
- One sub-module: paddle_hit_det (combinational). Takes current/next ball box, a paddle sprite_t and a side select. Returns hit, edge_top, edge_bot.
  - Instantiated twice, once per paddle.

Test Plan:
- Reset -> ball_o = {x 315, y 235, right 324, bottom 244}; pulses 0; ball_active_o 0. Frame ticks in IDLE leave ball_o unchanged.
- start_i, rnd_i=3'b011, then 60 frame ticks -> ball_active_o rises after 60th tick.
  - Next tick: x=313, y=236 (speed_y=1, dy=down).
- MOVE with y=12, dy=up, speed_y=3 -> y=10, dy=down. Mirrored at bottom: bottom clamps to 469.
- Player paddle x 10..20, y 200..250. Ball x=23, y=220, dx=left, speed_x=3 -> x=21, dx=right, speed_x=4, speed_y=1.
  - Same with y=196 -> speed_y=5, dy=up.
- Ball x=1, dx=left, speed_x=2, no overlap -> enemy_scored_o high exactly 1 cycle. Ball back at 315/235; SERVE; next launch dx=left.
- Assert rst_n_i low for 1 cycle mid-MOVE (asynchronous, between clock edges) -> outputs reset immediately. State IDLE; start_i required again.

Source files
------------

// File: rtl/ball_ctrl_pkg.sv
// rtl/ball_ctrl_pkg.sv - shared types and constants for the Pong ball engine
package ball_ctrl_pkg;

  localparam int X_POS_W   = 10;
  localparam int Y_POS_W   = 10;
  localparam int X_SW      = X_POS_W + 1;
  localparam int Y_SW      = Y_POS_W + 1;
  localparam int SPEED_W   = 5;
  localparam int SPEED_X_W = SPEED_W - 2;
  localparam int SPEED_Y_W = SPEED_W - 1;
  localparam int RND_NUM_W = 3;

  localparam int SCREEN_H_RES  = 640;
  localparam int SCREEN_V_RES  = 480;
  localparam int SCREEN_BORDER = 10;
  localparam int BALL_SIDE     = 10;

  localparam int BALL_CENTER_X = SCREEN_H_RES / 2 - BALL_SIDE / 2;
  localparam int BALL_CENTER_Y = SCREEN_V_RES / 2 - BALL_SIDE / 2;
  localparam int BASE_SPEED_X  = 2;
  localparam int MAX_SPEED_X   = 7;
  localparam int EDGE_ZONE     = 10;
  localparam int EDGE_SPEED_Y  = 5;
  localparam int MID_SPEED_Y   = 1;

  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORE} ball_state_t;

  typedef enum logic {SIDE_PLAYER = 1'b0, SIDE_ENEMY = 1'b1} paddle_side_t;

endpackage

// File: rtl/paddle_hit_det.sv
// rtl/paddle_hit_det.sv - combinational paddle crossing and edge-zone detector
module paddle_hit_det
  import ball_ctrl_pkg::*;
(
  input  logic [X_POS_W-1:0]     cur_x,
  input  logic [X_POS_W-1:0]     cur_right,
  input  logic signed [X_SW-1:0] nxt_x,
  input  logic signed [X_SW-1:0] nxt_right,
  input  logic signed [Y_SW-1:0] nxt_y,
  input  logic signed [Y_SW-1:0] nxt_bottom,
  input  sprite_t                paddle,
  input  paddle_side_t           side,
  output logic                   hit,
  output logic                   edge_top,
  output logic                   edge_bot
);

  localparam logic signed [Y_SW-1:0] HALF_SIDE = Y_SW'(BALL_SIDE / 2);
  localparam logic signed [Y_SW-1:0] EDGE_S    = Y_SW'(EDGE_ZONE);

  logic signed [X_SW-1:0] pad_left, pad_right, cur_left_s, cur_right_s;
  logic signed [Y_SW-1:0] pad_top, pad_bot, centre_y;
  logic                   crossed, overlap;

  assign pad_left    = $signed({1'b0, paddle.x_pos});
  assign pad_right   = $signed({1'b0, paddle.right});
  assign pad_top     = $signed({1'b0, paddle.y_pos});
  assign pad_bot     = $signed({1'b0, paddle.bottom});
  assign cur_left_s  = $signed({1'b0, cur_x});
  assign cur_right_s = $signed({1'b0, cur_right});
  assign centre_y    = nxt_y + HALF_SIDE;

  // A hit needs the ball face to cross the paddle face during this frame's step
  assign crossed = (side == SIDE_PLAYER) ?
                   ((cur_left_s > pad_right) && (nxt_x <= pad_right)) :
                   ((cur_right_s < pad_left) && (nxt_right >= pad_left));

  assign overlap  = (nxt_bottom >= pad_top) && (nxt_y <= pad_bot);
  assign hit      = crossed && overlap;
  assign edge_top = centre_y < (pad_top + EDGE_S);
  assign edge_bot = centre_y > (pad_bot - EDGE_S);

endmodule

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - Pong ball motion engine: serve, move, bounce, deflect, score
module ball_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int SERVE_FRAMES = 60
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 frame_tick_i,
  input  logic                 start_i,
  input  logic [RND_NUM_W-1:0] rnd_i,
  input  sprite_t              player_i,
  input  sprite_t              enemy_i,
  output sprite_t              ball_o,
  output logic                 player_scored_o,
  output logic                 enemy_scored_o,
  output logic                 ball_active_o
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [X_POS_W-1:0]   X_CENTER = X_POS_W'(BALL_CENTER_X);
  localparam logic [Y_POS_W-1:0]   Y_CENTER = Y_POS_W'(BALL_CENTER_Y);
  localparam logic [Y_POS_W-1:0]   Y_MIN    = Y_POS_W'(SCREEN_BORDER);
  localparam logic [Y_POS_W-1:0]   Y_MAX    = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER - BALL_SIDE);
  localparam logic [SPEED_X_W-1:0] SX_BASE  = SPEED_X_W'(BASE_SPEED_X);
  localparam logic [SPEED_X_W-1:0] SX_MAX   = SPEED_X_W'(MAX_SPEED_X);
  localparam logic [SPEED_Y_W-1:0] SY_EDGE  = SPEED_Y_W'(EDGE_SPEED_Y);
  localparam logic [SPEED_Y_W-1:0] SY_MID   = SPEED_Y_W'(MID_SPEED_Y);

  localparam logic signed [X_SW-1:0] X_SIDE_M1 = X_SW'(BALL_SIDE - 1);
  localparam logic signed [X_SW-1:0] X_LIMIT   = X_SW'(SCREEN_H_RES - 1);
  localparam logic signed [Y_SW-1:0] Y_SIDE_M1 = Y_SW'(BALL_SIDE - 1);
  localparam logic signed [Y_SW-1:0] Y_TOP_S   = Y_SW'(SCREEN_BORDER);
  localparam logic signed [Y_SW-1:0] Y_BOT_S   = Y_SW'(SCREEN_V_RES - 1 - SCREEN_BORDER);

  ball_state_t          state_q, state_d;
  logic [X_POS_W-1:0]   x_q, x_d;
  logic [Y_POS_W-1:0]   y_q, y_d;
  logic [SPEED_X_W-1:0] sx_q, sx_d;
  logic [SPEED_Y_W-1:0] sy_q, sy_d;
  logic                 dx_q, dx_d;  // 1 = moving right
  logic                 dy_q, dy_d;  // 1 = moving down
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 player_won_q, player_won_d;

  logic signed [X_SW-1:0] x_s, sx_s, nx, nx_right;
  logic signed [Y_SW-1:0] y_s, sy_s, ny, ny_bottom;
  logic [X_POS_W-1:0]     cur_right;
  logic [Y_POS_W-1:0]     cur_bottom;
  logic det_hit_p, det_top_p, det_bot_p, det_hit_e, det_top_e, det_bot_e;
  logic hit_p, hit_e, hit, edge_top, edge_bot, miss_l, miss_r;

  assign x_s        = $signed({1'b0, x_q});
  assign y_s        = $signed({1'b0, y_q});
  assign sx_s       = $signed({{(X_SW - SPEED_X_W){1'b0}}, sx_q});
  assign sy_s       = $signed({{(Y_SW - SPEED_Y_W){1'b0}}, sy_q});
  assign nx         = dx_q ? (x_s + sx_s) : (x_s - sx_s);
  assign ny         = dy_q ? (y_s + sy_s) : (y_s - sy_s);
  assign nx_right   = nx + X_SIDE_M1;
  assign ny_bottom  = ny + Y_SIDE_M1;
  assign cur_right  = x_q + X_POS_W'(BALL_SIDE - 1);
  assign cur_bottom = y_q + Y_POS_W'(BALL_SIDE - 1);

  paddle_hit_det u_player_det (
    .cur_x      (x_q),
    .cur_right  (cur_right),
    .nxt_x      (nx),
    .nxt_right  (nx_right),
    .nxt_y      (ny),
    .nxt_bottom (ny_bottom),
    .paddle     (player_i),
    .side       (SIDE_PLAYER),
    .hit        (det_hit_p),
    .edge_top   (det_top_p),
    .edge_bot   (det_bot_p)
  );

  paddle_hit_det u_enemy_det (
    .cur_x      (x_q),
    .cur_right  (cur_right),
    .nxt_x      (nx),
    .nxt_right  (nx_right),
    .nxt_y      (ny),
    .nxt_bottom (ny_bottom),
    .paddle     (enemy_i),
    .side       (SIDE_ENEMY),
    .hit        (det_hit_e),
    .edge_top   (det_top_e),
    .edge_bot   (det_bot_e)
  );

  assign hit_p    = det_hit_p && !dx_q;
  assign hit_e    = det_hit_e && dx_q;
  assign hit      = hit_p || hit_e;
  assign edge_top = hit_p ? det_top_p : det_top_e;
  assign edge_bot = hit_p ? det_bot_p : det_bot_e;
  assign miss_l   = nx[X_SW-1];
  assign miss_r   = nx_right > X_LIMIT;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    cnt_d        = cnt_q;
    player_won_d = player_won_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SERVE;
      end
      SERVE: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = MOVE;
            sx_d    = SX_BASE;
            dy_d    = rnd_i[0];
            sy_d    = SPEED_Y_W'(rnd_i[2:1]);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MOVE: begin
        if (frame_tick_i) begin
          if (!hit && (miss_l || miss_r)) begin
            state_d      = SCORE;
            player_won_d = miss_r;
          end else begin
            x_d = nx[X_POS_W-1:0];
            if (hit_p) begin
              x_d  = player_i.right + 1'b1;
              dx_d = 1'b1;
            end else if (hit_e) begin
              x_d  = enemy_i.x_pos - X_POS_W'(BALL_SIDE);
              dx_d = 1'b0;
            end
            if (hit) begin
              sx_d = (sx_q >= SX_MAX) ? SX_MAX : sx_q + 1'b1;
              if (edge_top) begin
                sy_d = SY_EDGE;
                dy_d = 1'b0;
              end else if (edge_bot) begin
                sy_d = SY_EDGE;
                dy_d = 1'b1;
              end else begin
                sy_d = SY_MID;
              end
            end
            // Wall correction is applied last so it overrides any edge-zone dy
            y_d = ny[Y_POS_W-1:0];
            if (ny < Y_TOP_S) begin
              y_d  = Y_MIN;
              dy_d = 1'b1;
            end else if (ny_bottom > Y_BOT_S) begin
              y_d  = Y_MAX;
              dy_d = 1'b0;
            end
          end
        end
      end
      SCORE: begin
        state_d = SERVE;
        x_d     = X_CENTER;
        y_d     = Y_CENTER;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      x_q          <= X_CENTER;
      y_q          <= Y_CENTER;
      sx_q         <= SX_BASE;
      sy_q         <= '0;
      dx_q         <= 1'b0;
      dy_q         <= 1'b1;
      cnt_q        <= '0;
      player_won_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      cnt_q        <= cnt_d;
      player_won_q <= player_won_d;
    end
  end

  assign ball_o          = '{x_pos: x_q, y_pos: y_q, right: cur_right, bottom: cur_bottom};
  assign ball_active_o   = (state_q == MOVE);
  assign player_scored_o = (state_q == SCORE) && player_won_q;
  assign enemy_scored_o  = (state_q == SCORE) && !player_won_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - directed self-checking bench for ball_ctrl
module tb_ball_ctrl;
  import ball_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 frame_tick;
  logic                 start;
  logic [RND_NUM_W-1:0] rnd;
  sprite_t              player;
  sprite_t              enemy;
  sprite_t              ball;
  logic                 player_scored;
  logic                 enemy_scored;
  logic                 ball_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_ctrl #(.SERVE_FRAMES(60)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .frame_tick_i    (frame_tick),
    .start_i         (start),
    .rnd_i           (rnd),
    .player_i        (player),
    .enemy_i         (enemy),
    .ball_o          (ball),
    .player_scored_o (player_scored),
    .enemy_scored_o  (enemy_scored),
    .ball_active_o   (ball_active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int ex, input int ey);
    chk({tag, ".x"}, 32'(ball.x_pos), ex);
    chk({tag, ".y"}, 32'(ball.y_pos), ey);
    chk({tag, ".right"}, 32'(ball.right), ex + 9);
    chk({tag, ".bottom"}, 32'(ball.bottom), ey + 9);
  endtask

  task automatic chk_flags(input string tag, input int ps, input int es, input int act);
    chk({tag, ".player_scored"}, 32'(player_scored), ps);
    chk({tag, ".enemy_scored"}, 32'(enemy_scored), es);
    chk({tag, ".active"}, 32'(ball_active), act);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic hard_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic press_start(input logic [RND_NUM_W-1:0] r);
    @(negedge clk);
    start = 1'b1;
    rnd   = r;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_launch(input string tag);
    frames(59);
    chk({tag, ".pre_launch_active"}, 32'(ball_active), 0);
    frames(1);
    chk({tag, ".launch_active"}, 32'(ball_active), 1);
  endtask

  task automatic set_paddles(input int py0, input int py1, input int ey0, input int ey1);
    player = '{x_pos: 10'd10, y_pos: 10'(py0), right: 10'd20, bottom: 10'(py1)};
    enemy  = '{x_pos: 10'd620, y_pos: 10'(ey0), right: 10'd630, bottom: 10'(ey1)};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    rnd        = '0;
    set_paddles(200, 250, 200, 250);
    repeat (2) @(negedge clk);
    chk_ball("reset", 315, 235);
    chk_flags("reset", 0, 0, 0);
    rst_n = 1'b1;
    frames(3);
    chk_ball("idle_ticks", 315, 235);
    chk_flags("idle_ticks", 0, 0, 0);

    // First serve: launch does not move, next frame steps (-2,+1)
    press_start(3'b011);
    wait_launch("serve1");
    chk_ball("launch_hold", 315, 235);
    frames(1);
    chk_ball("first_move", 313, 236);
    frames(2);
    chk_ball("pre_reset", 309, 238);

    // Asynchronous reset while clk is high
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_ball("async_reset", 315, 235);
    chk_flags("async_reset", 0, 0, 0);
    #1 rst_n = 1'b1;
    frames(3);
    chk_ball("post_reset_idle", 315, 235);
    chk_flags("post_reset_idle", 0, 0, 0);

    // Top wall: dy up, speed_y 3
    press_start(3'b110);
    wait_launch("top");
    frames(74);
    chk_ball("top_f74", 167, 13);
    frames(1);
    chk_ball("top_at_border", 165, 10);
    frames(1);
    chk_ball("top_clamp", 163, 10);
    frames(1);
    chk_ball("top_rebound", 161, 13);

    // Bottom wall: dy down, speed_y 3
    hard_reset();
    press_start(3'b111);
    wait_launch("bot");
    frames(75);
    chk_ball("bot_at_limit", 165, 460);
    frames(1);
    chk_ball("bot_clamp", 163, 460);
    frames(1);
    chk_ball("bot_rebound", 161, 457);

    // Player paddle, ball centre near paddle top
    hard_reset();
    set_paddles(235, 285, 200, 250);
    press_start(3'b001);
    wait_launch("etop");
    frames(147);
    chk_ball("etop_approach", 21, 235);
    frames(1);
    chk_ball("etop_hit", 21, 235);
    frames(1);
    chk_ball("etop_after1", 24, 230);
    frames(1);
    chk_ball("etop_after2", 27, 225);

    // Player paddle, ball centre near paddle bottom
    hard_reset();
    set_paddles(190, 245, 200, 250);
    press_start(3'b001);
    wait_launch("ebot");
    frames(148);
    chk_ball("ebot_hit", 21, 235);
    frames(1);
    chk_ball("ebot_after1", 24, 240);
    frames(1);
    chk_ball("ebot_after2", 27, 245);

    // Middle hit, then right-edge miss, then serve toward the loser and an enemy hit
    hard_reset();
    set_paddles(220, 270, 0, 50);
    press_start(3'b001);
    wait_launch("mid");
    frames(148);
    chk_ball("mid_hit", 21, 235);
    frames(1);
    chk_ball("mid_after1", 24, 236);
    frames(202);
    chk_ball("right_edge", 630, 438);
    chk_flags("right_edge", 0, 0, 1);
    frames(1);
    chk_flags("player_score", 1, 0, 0);
    @(negedge clk);
    chk_flags("player_score_end", 0, 0, 0);
    chk_ball("recentre_r", 315, 235);
    set_paddles(220, 270, 200, 300);
    wait_launch("serve_right");
    frames(1);
    chk_ball("serve_right_move", 317, 235);
    frames(147);
    chk_ball("enemy_hit", 610, 235);
    frames(1);
    chk_ball("enemy_after1", 607, 236);

    // Left-edge miss
    hard_reset();
    set_paddles(0, 50, 200, 250);
    press_start(3'b001);
    wait_launch("miss");
    frames(157);
    chk_ball("left_edge", 1, 235);
    frames(1);
    chk_flags("enemy_score", 0, 1, 0);
    @(negedge clk);
    chk_flags("enemy_score_end", 0, 0, 0);
    chk_ball("recentre_l", 315, 235);
    wait_launch("serve_left");
    frames(1);
    chk_ball("serve_left_move", 313, 235);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
